// File: rtl/hamming_pkg.sv
// Shared SECDED definitions for the 8-bit Hamming(12,8)+overall-parity code.
// Codeword positions 1..12: check bits at 1,2,4,8; data d0..d7 at 3,5,6,7,9,10,11,12.
package hamming_pkg;

   typedef struct packed {
      logic [3:0] p;
      logic       pall;
   } hamming_parity_t;

   localparam logic [3:0] DATA_POS [8] = '{4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12};

   // Check bit k covers every data bit whose codeword position has bit k set.
   function automatic logic [3:0] hamming_check8(input logic [7:0] d);
      logic [3:0] p;
      p = 4'd0;
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 4; k++) begin
            if (DATA_POS[i][k]) p[k] = p[k] ^ d[i];
         end
      end
      return p;
   endfunction

   function automatic hamming_parity_t hamming_encode8(input logic [7:0] d);
      hamming_parity_t c;
      c.p    = hamming_check8(d);
      c.pall = ^{d, c.p};
      return c;
   endfunction

   function automatic logic [3:0] hamming_syndrome8(input logic [7:0] d, input logic [3:0] p);
      return hamming_check8(d) ^ p;
   endfunction

endpackage

// File: rtl/top_hamming_ureg_if.sv
// Control and data bus of the SECDED-protected universal shift register.
interface top_hamming_ureg_if;
   logic       enable;
   logic [1:0] mode;
   logic       load;
   logic       serial_in;
   logic [7:0] parallel_in;
   logic       serial_out;
   logic [7:0] parallel_out;
   logic [7:0] pipo_out;
   logic [7:0] reg_data;

   modport master (
      output enable, mode, load, serial_in, parallel_in,
      input  serial_out, parallel_out, pipo_out, reg_data
   );

   modport slave (
      input  enable, mode, load, serial_in, parallel_in,
      output serial_out, parallel_out, pipo_out, reg_data
   );
endinterface

// File: rtl/hamming_secded_dec8.sv
// Combinational SECDED decoder: corrects single-bit data errors, flags double errors.
module hamming_secded_dec8 (
   input  logic [7:0] data_i,
   input  logic [3:0] p_i,
   input  logic       pall_i,
   output logic [7:0] corr_o,
   output logic       single_err_o,
   output logic       dbl_err_o
);
   import hamming_pkg::*;

   logic [3:0] syn;
   logic       ov;

   assign syn = hamming_syndrome8(data_i, p_i);
   assign ov  = ^{data_i, p_i, pall_i};

   // A syndrome pointing at a check-bit position (or at pall, s==0) leaves data untouched.
   always_comb begin
      corr_o = data_i;
      if (ov) begin
         for (int i = 0; i < 8; i++) begin
            if (syn == DATA_POS[i]) corr_o[i] = ~data_i[i];
         end
      end
   end

   assign single_err_o = ov;
   assign dbl_err_o    = !ov && (syn != 4'd0);

endmodule

// File: rtl/top_hamming_ureg.sv
// 8-bit universal shift register whose stored word is SECDED-protected and scrubbed every cycle.
module top_hamming_ureg (
   input  logic              clk,
   input  logic              rst,
   top_hamming_ureg_if.slave bus
);
   import hamming_pkg::*;

   localparam logic [1:0] MODE_SISO = 2'b00;
   localparam logic [1:0] MODE_SIPO = 2'b01;
   localparam logic [1:0] MODE_PISO = 2'b10;
   localparam logic [1:0] MODE_PIPO = 2'b11;

   logic [7:0]      reg_data_q, reg_data_d;
   logic [3:0]      p_q;
   logic            pall_q;
   hamming_parity_t chk_d;
   logic [7:0]      corr;
   logic            single_err, dbl_err;
   logic            unused_err_flags;

   hamming_secded_dec8 u_dec (
      .data_i       (reg_data_q),
      .p_i          (p_q),
      .pall_i       (pall_q),
      .corr_o       (corr),
      .single_err_o (single_err),
      .dbl_err_o    (dbl_err)
   );

   // Next word always derives from the corrected word, so holding also scrubs.
   always_comb begin
      reg_data_d = corr;
      if (bus.enable) begin
         case (bus.mode)
            MODE_SISO, MODE_SIPO: reg_data_d = {bus.serial_in, corr[7:1]};
            MODE_PISO:            reg_data_d = bus.load ? bus.parallel_in : {bus.serial_in, corr[7:1]};
            MODE_PIPO:            reg_data_d = bus.load ? bus.parallel_in : corr;
            default:              reg_data_d = corr;
         endcase
      end
   end

   assign chk_d = hamming_encode8(reg_data_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         reg_data_q <= 8'h00;
         p_q        <= 4'd0;
         pall_q     <= 1'b0;
      end else begin
         reg_data_q <= reg_data_d;
         p_q        <= chk_d.p;
         pall_q     <= chk_d.pall;
      end
   end

   assign bus.serial_out   = corr[0];
   assign bus.parallel_out = corr;
   assign bus.pipo_out     = (bus.mode == MODE_PIPO) ? corr : 8'h00;
   assign bus.reg_data     = reg_data_q;

   // Error flags are debug-visible only.
   assign unused_err_flags = single_err ^ dbl_err;

endmodule

// File: tb/tb_top_hamming_ureg.sv
// Directed bench for top_hamming_ureg: vector table plus fault-injection and reset sequences.
module tb_top_hamming_ureg;

   logic clk = 1'b0;
   logic rst;

   top_hamming_ureg_if bus ();

   top_hamming_ureg dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [1:0] mode;
      logic       load;
      logic       sin;
      logic [7:0] pin;
      logic [7:0] exp_reg;
      logic       exp_sout;
      logic [7:0] exp_pipo;
   } vec_t;

   vec_t vecs [17];
   int   errors = 0;
   int   checks = 0;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic [1:0] mode, input logic load,
                        input logic sin, input logic [7:0] pin);
      bus.enable      = en;
      bus.mode        = mode;
      bus.load        = load;
      bus.serial_in   = sin;
      bus.parallel_in = pin;
   endtask

   function automatic vec_t mk(input logic en, input logic [1:0] mode, input logic load,
                               input logic sin, input logic [7:0] pin, input logic [7:0] exp_reg,
                               input logic exp_sout, input logic [7:0] exp_pipo);
      vec_t v;
      v.en = en; v.mode = mode; v.load = load; v.sin = sin; v.pin = pin;
      v.exp_reg = exp_reg; v.exp_sout = exp_sout; v.exp_pipo = exp_pipo;
      return v;
   endfunction

   task automatic run_vec(input int i);
      drive(vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].sin, vecs[i].pin);
      step();
      check8($sformatf("v%0d reg_data", i), bus.reg_data, vecs[i].exp_reg);
      check8($sformatf("v%0d parallel_out", i), bus.parallel_out, vecs[i].exp_reg);
      check8($sformatf("v%0d serial_out", i), {7'd0, bus.serial_out}, {7'd0, vecs[i].exp_sout});
      check8($sformatf("v%0d pipo_out", i), bus.pipo_out, vecs[i].exp_pipo);
   endtask

   initial begin
      //             en mode   ld sin pin    reg    so  pipo
      vecs[0]  = mk(1, 2'b00, 0, 1, 8'h00, 8'h80, 0, 8'h00);
      vecs[1]  = mk(1, 2'b00, 0, 1, 8'h00, 8'hC0, 0, 8'h00);
      vecs[2]  = mk(1, 2'b00, 0, 1, 8'h00, 8'hE0, 0, 8'h00);
      vecs[3]  = mk(0, 2'b00, 0, 1, 8'h00, 8'hE0, 0, 8'h00);
      vecs[4]  = mk(1, 2'b11, 1, 0, 8'h00, 8'h00, 0, 8'h00);
      vecs[5]  = mk(1, 2'b01, 0, 1, 8'h00, 8'h80, 0, 8'h00);
      vecs[6]  = mk(1, 2'b01, 0, 0, 8'h00, 8'h40, 0, 8'h00);
      vecs[7]  = mk(1, 2'b01, 0, 0, 8'h00, 8'h20, 0, 8'h00);
      vecs[8]  = mk(1, 2'b01, 1, 0, 8'hFF, 8'h10, 0, 8'h00);
      vecs[9]  = mk(1, 2'b10, 1, 0, 8'hDB, 8'hDB, 1, 8'h00);
      vecs[10] = mk(1, 2'b10, 0, 0, 8'h00, 8'h6D, 1, 8'h00);
      vecs[11] = mk(1, 2'b10, 0, 0, 8'h00, 8'h36, 0, 8'h00);
      vecs[12] = mk(0, 2'b10, 1, 1, 8'hFF, 8'h36, 0, 8'h00);
      vecs[13] = mk(1, 2'b11, 1, 0, 8'hEF, 8'hEF, 1, 8'hEF);
      vecs[14] = mk(1, 2'b11, 0, 0, 8'h00, 8'hEF, 1, 8'hEF);
      vecs[15] = mk(1, 2'b00, 0, 1, 8'h00, 8'hF7, 1, 8'h00);
      vecs[16] = mk(1, 2'b00, 0, 1, 8'h00, 8'h80, 0, 8'h00);

      rst = 1'b1;
      drive(0, 2'b00, 0, 0, 8'h00);
      step();
      step();
      check8("reset reg_data", bus.reg_data, 8'h00);
      check8("reset parallel_out", bus.parallel_out, 8'h00);
      check8("reset serial_out", {7'd0, bus.serial_out}, 8'h00);
      check8("reset pipo_out", bus.pipo_out, 8'h00);
      check8("reset dbl_err", {7'd0, dut.dbl_err}, 8'h00);
      rst = 1'b0;

      for (int i = 0; i <= 3; i++) run_vec(i);

      // Single upset on data bit 7 (position 12) while holding.
      force dut.reg_data_q = 8'h60;
      #1;
      release dut.reg_data_q;
      check8("d7 upset raw", bus.reg_data, 8'h60);
      check8("d7 upset corrected", bus.parallel_out, 8'hE0);
      check8("d7 upset single_err", {7'd0, dut.single_err}, 8'h01);
      step();
      check8("d7 scrubbed", bus.reg_data, 8'hE0);

      // Upset on p[1]: E0 encodes to p=4'hD, pall=0.
      force dut.p_q = 4'hF;
      #1;
      release dut.p_q;
      check8("p1 upset data", bus.parallel_out, 8'hE0);
      check8("p1 upset single_err", {7'd0, dut.single_err}, 8'h01);
      step();
      check8("p1 scrubbed p", {4'd0, dut.p_q}, 8'h0D);
      check8("p1 scrubbed pall", {7'd0, dut.pall_q}, 8'h00);
      check8("p1 scrubbed data", bus.reg_data, 8'hE0);

      for (int i = 4; i <= 6; i++) run_vec(i);

      // Upset on data bit 2 coinciding with a shift: the shift must use the corrected word.
      force dut.reg_data_q = 8'h44;
      #1;
      release dut.reg_data_q;
      check8("d2 upset raw", bus.reg_data, 8'h44);
      check8("d2 upset corrected", bus.parallel_out, 8'h40);

      for (int i = 7; i <= 12; i++) run_vec(i);

      // Double upset on bits 5 and 4: detected, not corrected, re-encoded as-is.
      force dut.reg_data_q = 8'h06;
      #1;
      release dut.reg_data_q;
      check8("dbl dbl_err", {7'd0, dut.dbl_err}, 8'h01);
      check8("dbl single_err", {7'd0, dut.single_err}, 8'h00);
      check8("dbl parallel_out raw", bus.parallel_out, 8'h06);
      step();
      check8("dbl held reg_data", bus.reg_data, 8'h06);
      check8("dbl re-encoded dbl_err", {7'd0, dut.dbl_err}, 8'h00);

      for (int i = 13; i <= 15; i++) run_vec(i);

      // Asynchronous reset mid-operation.
      drive(1, 2'b11, 0, 1, 8'h00);
      rst = 1'b1;
      #1;
      check8("async rst reg_data", bus.reg_data, 8'h00);
      check8("async rst parallel_out", bus.parallel_out, 8'h00);
      check8("async rst serial_out", {7'd0, bus.serial_out}, 8'h00);
      check8("async rst pipo_out", bus.pipo_out, 8'h00);
      step();
      check8("rst held reg_data", bus.reg_data, 8'h00);
      rst = 1'b0;
      run_vec(16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
